mem_arbiter: RTL and testbench

Shares the single main-memory line port between the instruction-cache refill path and the data-cache refill/writeback path of the riscv core. Each cache raises a level request on a miss, which stalls its pipeline via pc_en/dhit. The arbiter grants one requester at a time with round-robin tie-breaking, drives the memory handshake, and returns the line and a one-cycle acknowledge. A bounded-wait watchdog aborts transactions the memory never completes.

---
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory line port between I-cache refill and D-cache refill/writeback.
// Ports: clk/reset (async active-low); ic_* I-cache read port; dc_* D-cache read/write port;
//        mem_* memory handshake; gnt_d = D-cache owns the port; mem_err = sticky watchdog abort flag.
module mem_arbiter #(
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [31:0]       ic_addr,
  output logic              ic_ack,
  output logic [LINE_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [31:0]       dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_ack,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              gnt_d,
  output logic              mem_err
);

  localparam logic [31:0] OFF_MASK = 32'(LINE_W / 8) - 32'd1;
  localparam logic [7:0]  TMO      = 8'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK} state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;   // 1 = D-cache owns the current transaction
  logic                last_q, last_d;     // last granted requester, 1 = D-cache
  logic [7:0]          cnt_q, cnt_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                ic_ack_q, ic_ack_d;
  logic                dc_ack_q, dc_ack_d;
  logic [LINE_W-1:0]   ic_rdata_q, ic_rdata_d;
  logic [LINE_W-1:0]   dc_rdata_q, dc_rdata_d;
  logic                gnt_dc_q, gnt_dc_d;
  logic                err_q, err_d;
  logic                pick_dc;

  // D wins if it is alone, or on a tie when the I-cache was served last.
  assign pick_dc = dc_req & (~ic_req | ~last_q);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ic_ack_d    = 1'b0;
    dc_ack_d    = 1'b0;
    ic_rdata_d  = ic_rdata_q;
    dc_rdata_d  = dc_rdata_q;
    gnt_dc_d    = gnt_dc_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (ic_req || dc_req) begin
          owner_d     = pick_dc;
          gnt_dc_d    = pick_dc;
          mem_we_d    = pick_dc & dc_we;
          mem_addr_d  = (pick_dc ? dc_addr : ic_addr) & ~OFF_MASK;
          mem_wdata_d = pick_dc ? dc_wdata : '0;
          cnt_d       = 8'd0;
          mem_req_d   = 1'b1;
          state_d     = S_BUSY;
        end
      end

      S_BUSY: begin
        if (mem_ready || cnt_q == TMO) begin
          // A completion arriving on the last allowed cycle still counts as good.
          if (mem_ready) begin
            if (!mem_we_q) begin
              if (owner_q) dc_rdata_d = mem_rdata;
              else         ic_rdata_d = mem_rdata;
            end
          end else begin
            err_d = 1'b1;
            if (owner_q) dc_rdata_d = '0;
            else         ic_rdata_d = '0;
          end
          mem_req_d = 1'b0;
          ic_ack_d  = ~owner_q;
          dc_ack_d  = owner_q;
          state_d   = S_ACK;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_ACK: begin
        last_d   = owner_q;
        gnt_dc_d = 1'b0;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b0;
      cnt_q       <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= '0;
      ic_ack_q    <= 1'b0;
      dc_ack_q    <= 1'b0;
      ic_rdata_q  <= '0;
      dc_rdata_q  <= '0;
      gnt_dc_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ic_ack_q    <= ic_ack_d;
      dc_ack_q    <= dc_ack_d;
      ic_rdata_q  <= ic_rdata_d;
      dc_rdata_q  <= dc_rdata_d;
      gnt_dc_q    <= gnt_dc_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign ic_ack    = ic_ack_q;
  assign dc_ack    = dc_ack_q;
  assign ic_rdata  = ic_rdata_q;
  assign dc_rdata  = dc_rdata_q;
  assign gnt_d     = gnt_dc_q;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: transaction-level scoreboard bench for mem_arbiter.
// Stimulus pushes expected transactions in arbitration order; a memory model serves them and
// a monitor checks every memory request and every acknowledge against the queue head.
module tb_mem_arbiter;

  typedef struct {
    bit           is_d;
    bit           we;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
    int           delay;   // extra cycles memory waits before mem_ready
    bit           dead;    // memory never answers
  } txn_t;

  logic         clk = 0;
  logic         reset = 0;
  logic         ic_req = 0;
  logic [31:0]  ic_addr = '0;
  logic         ic_ack;
  logic [127:0] ic_rdata;
  logic         dc_req = 0;
  logic         dc_we = 0;
  logic [31:0]  dc_addr = '0;
  logic [127:0] dc_wdata = '0;
  logic         dc_ack;
  logic [127:0] dc_rdata;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic         gnt_d;
  logic         mem_err;

  mem_arbiter #(.LINE_W(128), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_ack(dc_ack), .dc_rdata(dc_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .gnt_d(gnt_d), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  txn_t eq[$];          // expected transactions, checked by the monitor
  txn_t mq[$];          // same transactions, served by the memory model
  bit   last_d = 0;     // model: last granted requester
  bit   exp_err = 0;
  logic [127:0] exp_ic = '0;
  logic [127:0] exp_dc = '0;
  bit   stray_en = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic txn_t mk(input bit is_d, input bit we, input logic [31:0] addr,
                              input logic [127:0] wdata, input logic [127:0] rdata,
                              input int delay, input bit dead);
    txn_t t;
    t.is_d = is_d; t.we = we; t.addr = addr; t.wdata = wdata;
    t.rdata = rdata; t.delay = delay; t.dead = dead;
    return t;
  endfunction

  function automatic txn_t rnd(input bit is_d);
    return mk(is_d, is_d ? bit'($urandom_range(0, 1)) : 1'b0, $urandom,
              {$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 5), 1'b0);
  endfunction

  function automatic void model_reset();
    last_d = 0; exp_err = 0; exp_ic = '0; exp_dc = '0;
  endfunction

  task automatic push(input txn_t t);
    eq.push_back(t);
    mq.push_back(t);
  endtask

  task automatic drive(input txn_t t);
    if (t.is_d) begin
      dc_we = t.we; dc_addr = t.addr; dc_wdata = t.wdata; dc_req = 1;
    end else begin
      ic_addr = t.addr; ic_req = 1;
    end
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while ((eq.size() != 0 || ic_req || dc_req) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 2000) begin
      fails++;
      $display("FAIL %s: no completion after %0d cycles, %0d pending", nm, n, eq.size());
      eq.delete(); mq.delete(); ic_req = 0; dc_req = 0;
    end
    @(negedge clk);
  endtask

  // mode 0: a alone; 1: a and b raised together; 2: b raised one cycle after a
  task automatic issue(input int mode, input txn_t a, input txn_t b, input string nm);
    drive(a);
    if (mode == 0) begin
      push(a); last_d = a.is_d;
    end else if (mode == 1) begin
      drive(b);
      if (a.is_d != last_d) begin push(a); push(b); last_d = b.is_d; end
      else                  begin push(b); push(a); last_d = a.is_d; end
    end else begin
      push(a);
      @(negedge clk);
      drive(b); push(b); last_d = b.is_d;
    end
    wait_done(nm);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, " mem_req"},   128'(mem_req),   '0);
    chk({nm, " mem_we"},    128'(mem_we),    '0);
    chk({nm, " mem_addr"},  128'(mem_addr),  '0);
    chk({nm, " mem_wdata"}, mem_wdata,       '0);
    chk({nm, " ic_ack"},    128'(ic_ack),    '0);
    chk({nm, " dc_ack"},    128'(dc_ack),    '0);
    chk({nm, " ic_rdata"},  ic_rdata,        '0);
    chk({nm, " dc_rdata"},  dc_rdata,        '0);
    chk({nm, " gnt_d"},     128'(gnt_d),     '0);
    chk({nm, " mem_err"},   128'(mem_err),   '0);
  endtask

  // Requesters drop their request once they see their acknowledge.
  initial forever begin
    @(negedge clk);
    if (ic_ack) ic_req = 0;
    if (dc_ack) dc_req = 0;
  end

  // Memory model: serves mq in order, optionally throws stray mem_ready while idle.
  initial begin
    bit   active = 0;
    int   waited = 0;
    txn_t cur;
    mem_ready = 0;
    mem_rdata = '0;
    cur = mk(0, 0, '0, '0, '0, 0, 1);
    forever begin
      @(negedge clk);
      mem_ready = 0;
      if (!mem_req) begin
        active = 0;
        if (stray_en && reset && $urandom_range(0, 3) == 0) begin
          mem_ready = 1;
          mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        end
      end else begin
        if (!active) begin
          active = 1; waited = 0;
          if (mq.size() > 0) cur = mq.pop_front();
          else               cur.dead = 1;
        end
        if (!cur.dead && waited == cur.delay) begin
          mem_ready = 1;
          mem_rdata = cur.rdata;
        end
        waited++;
      end
    end
  end

  // Monitor: checks request fields when mem_req rises and results on every acknowledge.
  initial begin
    bit   req_prev = 0;
    int   req_cyc = 0;
    txn_t t;
    forever begin
      @(negedge clk);
      if (!reset) begin
        req_prev = 0; req_cyc = 0;
      end else begin
        if (mem_req && !req_prev) begin
          req_cyc = 0;
          if (eq.size() == 0) chk("spurious mem_req", 128'(mem_req), '0);
          else begin
            t = eq[0];
            chk("mem_addr", 128'(mem_addr), 128'(t.addr & 32'hFFFF_FFF0));
            chk("mem_we", 128'(mem_we), 128'(t.we));
            chk("gnt_d busy", 128'(gnt_d), 128'(t.is_d));
            if (t.we) chk("mem_wdata", mem_wdata, t.wdata);
          end
        end
        if (mem_req) req_cyc++;
        if (ic_ack || dc_ack) begin
          chk("ack exclusive", 128'(ic_ack & dc_ack), '0);
          if (eq.size() == 0) chk("unexpected ack", 128'({ic_ack, dc_ack}), '0);
          else begin
            t = eq.pop_front();
            chk("ack owner", 128'(dc_ack), 128'(t.is_d));
            if (t.dead) exp_err = 1;
            if (!t.is_d)      exp_ic = t.dead ? 128'd0 : t.rdata;
            else if (t.dead)  exp_dc = '0;
            else if (!t.we)   exp_dc = t.rdata;
            chk("ic_rdata", ic_rdata, exp_ic);
            chk("dc_rdata", dc_rdata, exp_dc);
            chk("mem_err", 128'(mem_err), 128'(exp_err));
            chk("mem_req cycles", 128'(req_cyc), t.dead ? 128'd256 : 128'(t.delay + 1));
            chk("mem_req low in ack", 128'(mem_req), '0);
            chk("gnt_d ack", 128'(gnt_d), 128'(t.is_d));
          end
        end
        req_prev = mem_req;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d pending", eq.size());
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t a, b;
    model_reset();
    #3;
    chk_reset_outputs("reset");
    @(negedge clk);
    reset = 1;
    @(negedge clk);

    // Ties from reset: D first, then strict alternation.
    issue(1, rnd(0), rnd(1), "tie1");
    issue(1, rnd(0), rnd(1), "tie2");

    issue(0, mk(0, 0, 32'h0000_1234, '0, {16{8'hA5}}, 3, 0), rnd(1), "lone I read");
    issue(0, mk(1, 1, 32'h8000_0010, {32{4'h1}}, {4{$urandom}}, 1, 0), rnd(0), "D writeback");
    issue(0, mk(1, 0, 32'h0000_2000, '0, {4{$urandom}}, 0, 1), rnd(0), "timeout");

    stray_en = 1;
    for (int i = 0; i < 40; i++) begin
      bit fd;
      fd = bit'($urandom_range(0, 1));
      a = rnd(fd);
      b = rnd(!fd);
      issue($urandom_range(0, 2), a, b, "random");
    end

    // Reset in the middle of a transaction; the still-pending request restarts afterwards.
    stray_en = 0;
    a = mk(0, 0, 32'h0000_4448, '0, {4{32'hDEAD_BEEF}}, 20, 0);
    drive(a);
    push(a);
    repeat (5) @(negedge clk);
    chk("mid-busy mem_req", 128'(mem_req), 128'd1);
    #2 reset = 0;
    #1;
    chk_reset_outputs("mid-busy reset");
    eq.delete();
    mq.delete();
    model_reset();
    a.delay = 2;
    a.rdata = {4{32'h0BAD_F00D}};
    push(a);
    @(negedge clk);
    reset = 1;
    wait_done("restart");

    chk("queue drained", 128'(eq.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
